// File: rtl/gbuff_reader.sv
// gbuff_reader: read-side sequencer for global_buffer.
// Issues a run of strided reads, absorbs the buffer's one-cycle read latency,
// and streams the returned words out through a small FIFO with a last marker.
// Optional feature macro: GBUFF_READER_STRIDE_EN (defined: the stride port sets
// the address increment; undefined: the increment is fixed at 1).
//
// Stream handshake: a word transfers on a rising edge where m_valid && m_ready;
// m_data/m_last are held stable while m_valid=1 and m_ready=0.
module gbuff_reader #(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   length,
    input  logic [ADDR_BITS-1:0] stride,
    output logic                 busy,
    output logic                 done,
    output logic                 gb_wr_en,
    output logic [ADDR_BITS-1:0] gb_index,
    input  logic [DATA_BITS-1:0] gb_data_out,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_last,
    output logic [1:0]           dbg_state
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE = PTR_W'(1);
    localparam logic [ADDR_BITS:0] REM_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS:0]   remaining_q, remaining_d;
    logic [ADDR_BITS-1:0] stride_q, stride_d;
    logic                 inflight_q, inflight_d;
    logic                 inflight_last_q, inflight_last_d;
    logic [ADDR_BITS-1:0] last_index_q, last_index_d;

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DATA_BITS-1:0] data_mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem_q;

    logic [ADDR_BITS-1:0] stride_sel;
    logic [CNT_W-1:0]     occupancy;
    logic                 push;
    logic                 pop;
    logic                 head_last;

`ifdef GBUFF_READER_STRIDE_EN
    assign stride_sel = stride;
`else
    // The port stays in the list so both builds share one interface.
    logic unused_stride;
    assign unused_stride = ^stride;
    assign stride_sel    = {{(ADDR_BITS-1){1'b0}}, 1'b1};
`endif

    assign gb_wr_en  = 1'b0;
    assign dbg_state = state_q;

    // A returned word arrives exactly one cycle after its issue.
    assign push      = inflight_q;
    assign m_valid   = (count_q != '0);
    assign pop       = m_valid && m_ready;
    assign head_last = last_mem_q[rd_ptr_q];
    assign m_data    = m_valid ? data_mem_q[rd_ptr_q] : '0;
    assign m_last    = m_valid && head_last;

    // Reserving a slot for the in-flight word keeps the FIFO from overflowing.
    assign occupancy = count_q + {{PTR_W{1'b0}}, inflight_q};

    // Command sequencing, read issue and status outputs.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        stride_d        = stride_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        last_index_d    = last_index_q;
        gb_index        = last_index_q;
        busy            = (state_q != S_IDLE);
        done            = (state_q == S_DONE);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = length;
                    stride_d    = stride_sel;
                    state_d     = (length == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if ((remaining_q != '0) && (occupancy < DEPTH_C)) begin
                    gb_index        = addr_q;
                    last_index_d    = addr_q;
                    inflight_d      = 1'b1;
                    inflight_last_d = (remaining_q == REM_ONE);
                    remaining_d     = remaining_q - REM_ONE;
                    addr_d          = addr_q + stride_q;
                    if (remaining_q == REM_ONE) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && head_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state; reset aborts any command and flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            stride_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            last_index_q    <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            stride_q        <= stride_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            last_index_q    <= last_index_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
        end
    end

    // FIFO storage; contents are only visible through m_valid-gated outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= gb_data_out;
            last_mem_q[wr_ptr_q] <= inflight_last_q;
        end
    end

endmodule

// File: tb/tb_gbuff_reader.sv
// Testbench for gbuff_reader with a behavioural global_buffer (gbuff[i]=i+1).
module tb_gbuff_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic [7:0] stride;
  logic       busy;
  logic       done;
  logic       gb_wr_en;
  logic [7:0] gb_index;
  logic [7:0] gb_data_out;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] got_q[$];
  logic       got_last_q[$];
  logic [7:0] exp_q[$];

  int         first_valid_cyc;
  int         last_hs_cyc;
  int         done_cyc;
  int         done_cnt;
  int         stall_viol;
  int         max_cnt;
  bit         timed_out;
  logic [7:0] idx_first;
  logic       busy_after;

  // clock / reset block
  always #5 clk = ~clk;

  // global_buffer model: synchronous read, contents gbuff[i] = i+1
  always @(posedge clk) gb_data_out <= gb_index + 8'd1;

  gbuff_reader #(.ADDR_BITS(8), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .length(length), .stride(stride), .busy(busy), .done(done),
    .gb_wr_en(gb_wr_en), .gb_index(gb_index), .gb_data_out(gb_data_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .dbg_state(dbg_state)
  );

  // driver: issues one command (caller is at a negedge) and records the stream.
  // mode 0: m_ready always 1; mode 1: m_ready pattern 1,0,0,1 repeating.
  // inj_cyc >= 0 raises start (base 100, length inj_len) for the edge after that cycle.
  task automatic run_cmd(input logic [7:0] b, input logic [8:0] len, input logic [7:0] s,
                         input int mode, input int inj_cyc, input logic [8:0] inj_len);
    int cyc;
    logic prev_valid, prev_ready, prev_last;
    logic [7:0] prev_data;
    got_q.delete();
    got_last_q.delete();
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1; done_cnt = 0;
    stall_viol = 0; max_cnt = 0; timed_out = 1'b0; idx_first = '0; busy_after = 1'b1;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_last = 1'b0; prev_data = '0;
    start = 1'b1; base_addr = b; length = len; stride = s; m_ready = (mode == 0);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) idx_first = gb_index;
      if (prev_valid && !prev_ready && m_valid)
        if (m_data !== prev_data || m_last !== prev_last) stall_viol++;
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (int'(dut.count_q) > max_cnt) max_cnt = int'(dut.count_q);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = busy;
        break;
      end
      if (cyc >= 200) begin
        timed_out = 1'b1;
        break;
      end
      m_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 1) || (cyc % 4 == 0));
      if (cyc == inj_cyc) begin
        start = 1'b1; base_addr = 8'd100; length = inj_len; stride = 8'd1;
      end
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        got_last_q.push_back(m_last);
        if (m_last) last_hs_cyc = cyc;
      end
      prev_valid = m_valid; prev_ready = m_ready; prev_data = m_data; prev_last = m_last;
    end
    start = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; stride = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    n_cmp++; if (m_data !== 8'd0) begin n_bad++; $display("FAIL reset_m_data: got %0d expected 0", m_data); end
    n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
    n_cmp++; if (gb_index !== 8'd0) begin n_bad++; $display("FAIL reset_gb_index: got %0d expected 0", gb_index); end
    n_cmp++; if (gb_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_gb_wr_en: got %b expected 0", gb_wr_en); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    exp_q = '{8'd6, 8'd7, 8'd8, 8'd9};
    run_cmd(8'd5, 9'd4, 8'd1, 0, -1, 9'd0);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL basic_timeout: got timeout expected completion"); end
    n_cmp++; if (idx_first !== 8'd5) begin n_bad++; $display("FAIL basic_first_index: got %0d expected 5", idx_first); end
    n_cmp++; if (first_valid_cyc != 3) begin n_bad++; $display("FAIL basic_latency: got cycle %0d expected 3", first_valid_cyc); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL basic_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL basic_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
      n_cmp++; if (got_last_q[i] !== (i == exp_q.size() - 1)) begin n_bad++; $display("FAIL basic_last[%0d]: got %b expected %b", i, got_last_q[i], (i == exp_q.size() - 1)); end
    end
    n_cmp++; if (last_hs_cyc != 6) begin n_bad++; $display("FAIL basic_no_bubbles: last handshake cycle %0d expected 6", last_hs_cyc); end
    n_cmp++; if (done_cyc != 7) begin n_bad++; $display("FAIL basic_done_cycle: got %0d expected 7", done_cyc); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL basic_done_width: got %0d expected 1", done_cnt); end
    n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after: got %b expected 0", busy_after); end
    n_cmp++; if (gb_index !== 8'd8) begin n_bad++; $display("FAIL basic_index_hold: got %0d expected 8", gb_index); end
  endtask

  task automatic test_backpressure();
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    run_cmd(8'd0, 9'd10, 8'd1, 1, -1, 9'd0);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL bp_timeout: got timeout expected completion"); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bp_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
      n_cmp++; if (got_last_q[i] !== (i == exp_q.size() - 1)) begin n_bad++; $display("FAIL bp_last[%0d]: got %b expected %b", i, got_last_q[i], (i == exp_q.size() - 1)); end
    end
    n_cmp++; if (stall_viol != 0) begin n_bad++; $display("FAIL bp_stable: got %0d changes under stall expected 0", stall_viol); end
    n_cmp++; if (max_cnt > 4) begin n_bad++; $display("FAIL bp_overflow: max fifo count %0d expected <= 4", max_cnt); end
    n_cmp++; if (done_cyc != last_hs_cyc + 1) begin n_bad++; $display("FAIL bp_done_cycle: got %0d expected %0d", done_cyc, last_hs_cyc + 1); end
  endtask

  task automatic test_wrap_stride();
`ifdef GBUFF_READER_STRIDE_EN
    exp_q = '{8'd251, 8'd254, 8'd1, 8'd4};
`else
    exp_q = '{8'd251, 8'd252, 8'd253, 8'd254};
`endif
    run_cmd(8'd250, 9'd4, 8'd3, 0, -1, 9'd0);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL wrap_timeout: got timeout expected completion"); end
    n_cmp++; if (idx_first !== 8'd250) begin n_bad++; $display("FAIL wrap_first_index: got %0d expected 250", idx_first); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL wrap_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL wrap_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_len_zero();
    run_cmd(8'd7, 9'd0, 8'd1, 0, -1, 9'd0);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL len0_timeout: got timeout expected completion"); end
    n_cmp++; if (done_cyc != 1) begin n_bad++; $display("FAIL len0_done_cycle: got %0d expected 1", done_cyc); end
    n_cmp++; if (first_valid_cyc != -1) begin n_bad++; $display("FAIL len0_no_valid: m_valid seen at cycle %0d expected never", first_valid_cyc); end
    n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL len0_busy_after: got %b expected 0", busy_after); end
  endtask

  task automatic test_start_while_busy();
    exp_q = '{8'd31, 8'd32, 8'd33, 8'd34, 8'd35};
    run_cmd(8'd30, 9'd5, 8'd1, 0, 2, 9'd3);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL busy_timeout: got timeout expected completion"); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL busy_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL busy_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL busy_busy_after: got %b expected 0", busy_after); end
  endtask

  task automatic test_start_in_done();
    exp_q = '{8'd41, 8'd42, 8'd43};
    run_cmd(8'd40, 9'd3, 8'd1, 0, 6, 9'd2);
    n_cmp++; if (done_cyc != 6) begin n_bad++; $display("FAIL done_start_cycle: got %0d expected 6", done_cyc); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL done_start_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL done_start_ignored: busy %b expected 0", busy_after); end
    @(negedge clk);
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL done_start_no_stream: m_valid %b expected 0", m_valid); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int bad_cnt;
    got_q.delete();
    start = 1'b1; base_addr = 8'd0; length = 9'd8; stride = 8'd1; m_ready = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (m_valid && m_ready) got_q.push_back(m_data);
      if (got_q.size() == 3 || cyc >= 20) break;
    end
    n_cmp++; if (got_q.size() != 3) begin n_bad++; $display("FAIL rstmid_pre_count: got %0d expected 3", got_q.size()); end
    n_cmp++; if (cyc != 5) begin n_bad++; $display("FAIL rstmid_pre_cycle: got %0d expected 5", cyc); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_m_valid: got %b expected 0", m_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    bad_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_valid || done) bad_cnt++;
    end
    n_cmp++; if (bad_cnt != 0) begin n_bad++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", bad_cnt); end
    exp_q = '{8'd21, 8'd22};
    run_cmd(8'd20, 9'd2, 8'd1, 0, -1, 9'd0);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rstmid_new_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rstmid_new_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap_stride();
    test_len_zero();
    test_start_while_busy();
    test_start_in_done();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
